// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution layer sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdFeat,
    StLdBias,
    StLdWgt,
    StCompute,
    StSend,
    StDone,
    StErr
  } conv_state_e;

  // S_AXIS writer steering codes
  localparam logic [1:0] RxNone = 2'd0;
  localparam logic [1:0] RxFeat = 2'd1;
  localparam logic [1:0] RxBias = 2'd2;
  localparam logic [1:0] RxWgt  = 2'd3;

  // Output bytes per AXIS beat (32-bit TDATA)
  localparam int unsigned BYTES_PER_BEAT = 4;

  // Channels in a tile given the channels still to be produced
  function automatic logic [4:0] clamp_cnt(input logic [9:0] remaining,
                                           input int unsigned oc_par);
    return (remaining >= 10'(oc_par)) ? 5'(oc_par) : remaining[4:0];
  endfunction

endpackage

// File: rtl/conv_tile_calc.sv
// Tile bookkeeping: first/next tile channel counts and beats per tile send.
module conv_tile_calc #(
  parameter int unsigned OC_PAR         = 4,
  parameter int unsigned BYTES_PER_BEAT = conv_ctrl_pkg::BYTES_PER_BEAT
) (
  input  logic [8:0]  num_outch,
  input  logic [5:0]  flen,
  input  logic [8:0]  oc_base,
  input  logic [4:0]  oc_cnt,
  output logic [4:0]  first_cnt,
  output logic [8:0]  next_base,
  output logic [4:0]  next_cnt,
  output logic        last_tile,
  output logic [15:0] tx_beats
);
  import conv_ctrl_pkg::*;

  logic [9:0]  sum;
  logic [9:0]  remaining;
  logic [19:0] tile_bytes;

  // Tile arithmetic; 20-bit intermediates cover 63*63*16 plus rounding
  always_comb begin
    sum        = {1'b0, oc_base} + {5'd0, oc_cnt};
    remaining  = {1'b0, num_outch} - sum;
    first_cnt  = clamp_cnt({1'b0, num_outch}, OC_PAR);
    next_base  = sum[8:0];
    // remaining is only meaningful when this is not the last tile
    next_cnt   = clamp_cnt(remaining, OC_PAR);
    last_tile  = (sum >= {1'b0, num_outch});
    tile_bytes = 20'(flen) * 20'(flen) * 20'(oc_cnt);
    tx_beats   = 16'((tile_bytes + 20'(BYTES_PER_BEAT - 1)) / 20'(BYTES_PER_BEAT));
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Layer-level sequencer: feature load, bias load, then per-tile weight/MAC/send.
module conv_seq_ctrl #(
  parameter int unsigned OC_PAR         = 4,
  parameter int unsigned BYTES_PER_BEAT = conv_ctrl_pkg::BYTES_PER_BEAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conv_start,
  input  logic [8:0]  num_inch,
  input  logic [8:0]  num_outch,
  input  logic [5:0]  flen,
  input  logic        f_writedone,
  input  logic        b_writedone,
  input  logic        w_writedone,
  input  logic        mac_done,
  input  logic        tx_done,
  output logic [1:0]  rx_sel,
  output logic        mac_start,
  output logic [8:0]  oc_base,
  output logic [4:0]  oc_cnt,
  output logic        tx_start,
  output logic [15:0] tx_beats,
  output logic        rdy_to_send,
  output logic        busy,
  output logic        conv_done,
  output logic        cfg_err
);
  import conv_ctrl_pkg::*;

  conv_state_e state_q;
  logic        start_prev_q;
  logic [8:0]  num_outch_q;
  logic [5:0]  flen_q;
  logic        start_evt;

  logic [4:0]  first_cnt;
  logic [8:0]  next_base;
  logic [4:0]  next_cnt;
  logic        last_tile;
  logic [15:0] calc_beats;

  // Rising edge of the APB start level
  always_comb begin
    start_evt = conv_start & ~start_prev_q;
  end

  conv_tile_calc #(
    .OC_PAR        (OC_PAR),
    .BYTES_PER_BEAT(BYTES_PER_BEAT)
  ) u_tile_calc (
    .num_outch(num_outch_q),
    .flen     (flen_q),
    .oc_base  (oc_base),
    .oc_cnt   (oc_cnt),
    .first_cnt(first_cnt),
    .next_base(next_base),
    .next_cnt (next_cnt),
    .last_tile(last_tile),
    .tx_beats (calc_beats)
  );

  // Sequencer FSM with registered outputs; done pulses only count in their own state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      num_outch_q  <= '0;
      flen_q       <= '0;
      rx_sel       <= RxNone;
      mac_start    <= 1'b0;
      oc_base      <= '0;
      oc_cnt       <= '0;
      tx_start     <= 1'b0;
      tx_beats     <= '0;
      rdy_to_send  <= 1'b0;
      busy         <= 1'b0;
      conv_done    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      start_prev_q <= conv_start;
      mac_start    <= 1'b0;
      tx_start     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            // num_inch is only validated; the datapath keeps its own copy
            num_outch_q <= num_outch;
            flen_q      <= flen;
            if (num_outch == '0 || flen == '0 || num_inch == '0) begin
              cfg_err <= 1'b1;
              state_q <= StErr;
            end else begin
              cfg_err <= 1'b0;
              rx_sel  <= RxFeat;
              busy    <= 1'b1;
              state_q <= StLdFeat;
            end
          end
        end
        StLdFeat: begin
          if (f_writedone) begin
            rx_sel  <= RxBias;
            state_q <= StLdBias;
          end
        end
        StLdBias: begin
          if (b_writedone) begin
            oc_base <= '0;
            oc_cnt  <= first_cnt;
            rx_sel  <= RxWgt;
            state_q <= StLdWgt;
          end
        end
        StLdWgt: begin
          if (w_writedone) begin
            rx_sel    <= RxNone;
            mac_start <= 1'b1;
            state_q   <= StCompute;
          end
        end
        StCompute: begin
          if (mac_done) begin
            tx_beats    <= calc_beats;
            tx_start    <= 1'b1;
            rdy_to_send <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (tx_done) begin
            rdy_to_send <= 1'b0;
            if (last_tile) begin
              busy      <= 1'b0;
              conv_done <= 1'b1;
              state_q   <= StDone;
            end else begin
              oc_base <= next_base;
              oc_cnt  <= next_cnt;
              rx_sel  <= RxWgt;
              state_q <= StLdWgt;
            end
          end
        end
        StDone: begin
          if (!conv_start) begin
            conv_done <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StErr: begin
          if (!conv_start) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl with a randomized datapath responder.
module tb_conv_seq_ctrl;
  localparam int unsigned OC_PAR = 4;
  localparam int unsigned BPB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        conv_start;
  logic [8:0]  num_inch;
  logic [8:0]  num_outch;
  logic [5:0]  flen;
  logic        f_writedone, b_writedone, w_writedone, mac_done, tx_done;
  logic [1:0]  rx_sel;
  logic        mac_start;
  logic [8:0]  oc_base;
  logic [4:0]  oc_cnt;
  logic        tx_start;
  logic [15:0] tx_beats;
  logic        rdy_to_send, busy, conv_done, cfg_err;

  always #5 clk = ~clk;

  conv_seq_ctrl #(
    .OC_PAR        (OC_PAR),
    .BYTES_PER_BEAT(BPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .conv_start (conv_start),
    .num_inch   (num_inch),
    .num_outch  (num_outch),
    .flen       (flen),
    .f_writedone(f_writedone),
    .b_writedone(b_writedone),
    .w_writedone(w_writedone),
    .mac_done   (mac_done),
    .tx_done    (tx_done),
    .rx_sel     (rx_sel),
    .mac_start  (mac_start),
    .oc_base    (oc_base),
    .oc_cnt     (oc_cnt),
    .tx_start   (tx_start),
    .tx_beats   (tx_beats),
    .rdy_to_send(rdy_to_send),
    .busy       (busy),
    .conv_done  (conv_done),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    int base;
    int cnt;
    int beats;
  } tile_t;

  tile_t exp_q[$];
  int    n_cmp     = 0;
  int    n_err     = 0;
  int    mac_cnt   = 0;
  int    tx_cnt    = 0;
  int    tx_served = 0;
  int    tx_limit  = 1 << 30;
  bit    resp_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: tiles of OC_PAR channels, last one short; beats round bytes up
  task automatic model_tiles(input int outch, input int fl, output int n);
    n = 0;
    for (int base = 0; base < outch; base += OC_PAR) begin
      tile_t t;
      t.base  = base;
      t.cnt   = (outch - base < int'(OC_PAR)) ? outch - base : int'(OC_PAR);
      t.beats = (fl * fl * t.cnt + int'(BPB) - 1) / int'(BPB);
      exp_q.push_back(t);
      n++;
    end
  endtask

  // Datapath stand-in: answers each phase request after 0..3 idle cycles
  initial begin : responder
    int unsigned dly;
    int          kind;
    bit          comp_pend;
    kind      = 0;
    comp_pend = 1'b0;
    dly       = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        kind      = 0;
        comp_pend = 1'b0;
      end else begin
        f_writedone = 1'b0;
        b_writedone = 1'b0;
        w_writedone = 1'b0;
        mac_done    = 1'b0;
        tx_done     = 1'b0;
        if (rst) begin
          kind      = 0;
          comp_pend = 1'b0;
        end else begin
          if (mac_start) comp_pend = 1'b1;
          if (kind == 0) begin
            if (rx_sel == 2'd1) kind = 1;
            else if (rx_sel == 2'd2) kind = 2;
            else if (rx_sel == 2'd3) kind = 3;
            else if (comp_pend) kind = 4;
            else if (rdy_to_send && tx_served < tx_limit) kind = 5;
            dly = $urandom_range(0, 3);
          end
          if (kind != 0) begin
            if (dly == 0) begin
              case (kind)
                1: f_writedone = 1'b1;
                2: b_writedone = 1'b1;
                3: w_writedone = 1'b1;
                4: begin mac_done = 1'b1; comp_pend = 1'b0; end
                default: begin tx_done = 1'b1; tx_served++; end
              endcase
              kind = 0;
            end else begin
              dly--;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the expected tile on every tx_start
  initial begin : monitor
    bit    prev_mac;
    bit    prev_tx;
    tile_t t;
    prev_mac = 1'b0;
    prev_tx  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mac_start) begin
          mac_cnt++;
          check("mac_start_width", prev_mac, 0);
          check("rx_sel_idle_in_compute", rx_sel, 0);
        end
        if (tx_start) begin
          tx_cnt++;
          check("tx_start_width", prev_tx, 0);
          check("rdy_to_send_at_tx_start", rdy_to_send, 1);
          check("mac_tx_pairing", mac_cnt, tx_cnt);
          if (exp_q.size() == 0) begin
            check("unexpected_tile", 1, 0);
          end else begin
            t = exp_q.pop_front();
            check("oc_base", oc_base, t.base);
            check("oc_cnt", oc_cnt, t.cnt);
            check("tx_beats", tx_beats, t.beats);
          end
        end
      end
      prev_mac = mac_start;
      prev_tx  = tx_start;
    end
  end

  function automatic longint all_outs();
    return longint'({rx_sel, mac_start, oc_base, oc_cnt, tx_start, tx_beats,
                     rdy_to_send, busy, conv_done, cfg_err});
  endfunction

  task automatic start_layer(input int inch, input int outch, input int fl,
                             output int ntiles, output int tx0);
    model_tiles(outch, fl, ntiles);
    tx0        = tx_cnt;
    num_inch   = 9'(inch);
    num_outch  = 9'(outch);
    flen       = 6'(fl);
    conv_start = 1'b1;
    @(negedge clk);
    check("enter_ld_feat", rx_sel, 1);
    check("busy_after_start", busy, 1);
    check("cfg_err_clear_on_start", cfg_err, 0);
  endtask

  task automatic finish_layer(input int ntiles, input int tx0, input int hold);
    int cyc;
    cyc = 0;
    while (!conv_done && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    check("layer_done_in_time", conv_done, 1);
    if (!conv_done) begin
      rst        = 1'b1;
      conv_start = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      return;
    end
    check("tile_count", tx_cnt - tx0, ntiles);
    check("queue_drained", exp_q.size(), 0);
    check("busy_in_done", busy, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("conv_done_held", conv_done, 1);
    end
    conv_start = 1'b0;
    @(negedge clk);
    check("conv_done_cleared", conv_done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_layer(input int inch, input int outch, input int fl, input int hold);
    int ntiles;
    int tx0;
    start_layer(inch, outch, fl, ntiles, tx0);
    finish_layer(ntiles, tx0, hold);
  endtask

  initial begin : main
    int ntiles, tx0, mac0, cyc;
    bit rx_seen;
    int bad [3][3];
    rst         = 1'b1;
    conv_start  = 1'b0;
    num_inch    = '0;
    num_outch   = '0;
    flen        = '0;
    f_writedone = 1'b0;
    b_writedone = 1'b0;
    w_writedone = 1'b0;
    mac_done    = 1'b0;
    tx_done     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst     = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);

    // Two full tiles, then one short final tile
    run_layer(3, 8, 4, 0);
    run_layer(7, 6, 5, 0);

    // Each zero field is a configuration error; cfg_err is sticky until restart
    bad = '{'{3, 0, 4}, '{3, 5, 0}, '{0, 5, 4}};
    for (int k = 0; k < 3; k++) begin
      num_inch   = 9'(bad[k][0]);
      num_outch  = 9'(bad[k][1]);
      flen       = 6'(bad[k][2]);
      conv_start = 1'b1;
      rx_seen    = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (rx_sel != 2'd0) rx_seen = 1'b1;
      end
      check("err_cfg_err_set", cfg_err, 1);
      check("err_no_rx_activity", rx_seen, 0);
      check("err_not_busy", busy, 0);
      conv_start = 1'b0;
      repeat (2) @(negedge clk);
      check("err_cfg_err_sticky", cfg_err, 1);
      run_layer(3, 5, 3, 0);
    end

    // Spurious done pulses and a second start edge while loading features
    resp_en = 1'b0;
    @(negedge clk);
    mac0 = mac_cnt;
    start_layer(4, 4, 2, ntiles, tx0);
    mac_done    = 1'b1;
    tx_done     = 1'b1;
    b_writedone = 1'b1;
    w_writedone = 1'b1;
    conv_start  = 1'b0;
    @(negedge clk);
    mac_done    = 1'b0;
    tx_done     = 1'b0;
    b_writedone = 1'b0;
    w_writedone = 1'b0;
    conv_start  = 1'b1;
    repeat (3) @(negedge clk);
    check("spurious_rx_sel", rx_sel, 1);
    check("spurious_busy", busy, 1);
    check("spurious_no_pulses", (mac_cnt - mac0) + (tx_cnt - tx0), 0);
    resp_en = 1'b1;
    finish_layer(ntiles, tx0, 0);

    // Asynchronous reset during the second SEND
    tx_limit = tx_served + 1;
    start_layer(5, 8, 6, ntiles, tx0);
    cyc = 0;
    while (!((tx_cnt - tx0) == 2 && rdy_to_send) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("second_send_reached", tx_cnt - tx0, 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    exp_q.delete();
    conv_start = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    tx_limit = 1 << 30;
    @(negedge clk);
    check("post_reset_idle", busy, 0);
    run_layer(5, 8, 6, 0);

    // Hold start after DONE
    run_layer(2, 9, 3, 10);

    // Largest configuration, then random layers
    run_layer(511, 511, 63, 0);
    for (int r = 0; r < 6; r++) begin
      run_layer(int'($urandom_range(1, 511)), int'($urandom_range(1, 40)),
                int'($urandom_range(1, 63)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Layer-level sequencer for the convolution datapath. It takes the layer configuration and the start request from the APB register block, then steps the conv datapath through its phases: feature load, bias load, then a per-tile loop of weight load, MAC compute and AXIS result send. It returns a done handshake to the APB side. It sits between the APB register block and the conv datapath, and replaces ad-hoc phase commands issued by software.

Parameters:
OC_PAR, 4, output channels computed per tile (1..16)
BYTES_PER_BEAT, 4, output bytes per AXIS beat (32-bit TDATA)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
conv_start  in  1  level request from APB; a rising edge starts a layer
num_inch  in  9  input channel count, sampled at start
num_outch  in  9  output channel count, sampled at start
flen  in  6  feature map side length, sampled at start
f_writedone  in  1  pulse: feature buffer fully written
b_writedone  in  1  pulse: bias buffer fully written
w_writedone  in  1  pulse: weight buffer for current tile written
mac_done  in  1  pulse: tile computation finished
tx_done  in  1  pulse: last beat of tile accepted (TLAST and TREADY)
rx_sel  out  2  0 none, 1 feature, 2 bias, 3 weight; steers the S_AXIS writer
mac_start  out  1  one-cycle pulse starting tile compute
oc_base  out  9  first output channel of the current tile
oc_cnt  out  5  channels in the current tile (1..OC_PAR)
tx_start  out  1  one-cycle pulse starting the tile send
tx_beats  out  16  beats to send for the current tile
rdy_to_send  out  1  high during SEND
busy  out  1  high in every state except IDLE, DONE and ERR
conv_done  out  1  completion flag
cfg_err  out  1  sticky configuration error

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, all internal counters 0, start edge detector primed to 0.
- Start detect: a registered copy of conv_start; start_evt = conv_start & ~prev. start_evt is ignored outside IDLE.
- IDLE, on start_evt:
  - latch num_inch, num_outch and flen.
  - if num_outch==0, flen==0 or num_inch==0: go to ERR next cycle.
  - otherwise go to LD_FEAT with rx_sel=1.
- LD_FEAT, on f_writedone: go to LD_BIAS with rx_sel=2.
- LD_BIAS, on b_writedone: set oc_base=0 and oc_cnt=min(OC_PAR, num_outch), then go to LD_WGT with rx_sel=3.
- LD_WGT, on w_writedone: rx_sel=0, pulse mac_start in the first COMPUTE cycle.
- COMPUTE, on mac_done: tx_beats = ceil(flen*flen*oc_cnt / BYTES_PER_BEAT), computed with ≥16-bit intermediates. Pulse tx_start in the first SEND cycle; rdy_to_send=1.
- SEND, on tx_done: rdy_to_send=0.
  - if oc_base+oc_cnt ≥ num_outch: go to DONE.
  - otherwise oc_base += oc_cnt, oc_cnt = min(OC_PAR, num_outch − new oc_base), go to LD_WGT with rx_sel=3.
- DONE: conv_done=1, held until conv_start is sampled low, then go to IDLE with conv_done cleared in the same cycle.
- ERR: cfg_err=1; leave when conv_start is sampled low and go to IDLE. cfg_err stays set until the next accepted start_evt clears it.
- Done pulses (f/b/w_writedone, mac_done, tx_done) arriving outside their owning state are ignored, not queued.
- A done pulse that coincides with the state's entry cycle is honoured.
- Latency: every transition is one clock after the qualifying input; mac_start and tx_start are registered pulses exactly one cycle wide.
- Last tile: a short final tile produces oc_cnt < OC_PAR. oc_base never exceeds num_outch−1.
- rst asserted mid-layer aborts immediately: outputs return to reset values and the datapath is expected to be reset by the same rst.

Decomposition:
- Shared package conv_ctrl_pkg holds:
  - state encoding (IDLE, LD_FEAT, LD_BIAS, LD_WGT, COMPUTE, SEND, DONE, ERR; 3-bit)
  - rx_sel codes
  - helper constant BYTES_PER_BEAT
- One natural sub-module, conv_tile_calc: combinational/registered computation of next oc_cnt and tx_beats. It keeps the multiply off the FSM path and is verifiable in isolation.

Test Plan:
1. num_inch=3, num_outch=8, flen=4, OC_PAR=4, with ideal done pulses 3 cycles after each request: expect exactly two mac_start/tx_start pairs, oc_base 0 then 4, tx_beats=16 each, then conv_done=1.
2. num_outch=6, flen=5, OC_PAR=4: expect tile 2 with oc_base=4, oc_cnt=2 and tx_beats=ceil(50/4)=13, then DONE.
3. num_outch=0 with start: expect ERR, cfg_err=1, no rx_sel activity. Drop conv_start, then restart with a valid config: cfg_err clears and LD_FEAT is entered.
4. Spurious mac_done and tx_done during LD_FEAT, and a second conv_start edge while busy: expect no state change and no extra pulses.
5. Assert rst during the second SEND: all outputs are 0 within the same cycle (async), state is IDLE, and a new start runs a full layer normally.
6. Hold conv_start high after DONE for 10 cycles: conv_done stays 1. Drop it: conv_done falls at the next edge and busy stays 0.
